// File: rtl/lvds_tx_bridge_pkg.sv
// rtl/lvds_tx_bridge_pkg.sv - shared constants for the LVDS transmit bridge
//
// Purpose: FSM state encoding and the default lane training pattern.
// The states are plain localparams so older modules that compare the state
// against raw bit values keep working.
// Ports: none (package).

package lvds_tx_bridge_pkg;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ACK = 1'b1;

    localparam logic [7:0] TRAIN_PATTERN_DEFAULT = 8'hA5;

endpackage

// File: rtl/ff_synch.sv
// rtl/ff_synch.sv - multi-stage flip-flop synchroniser for a single-bit level
//
// Purpose: brings an asynchronous level into the clk domain through STAGES
// back-to-back flops (STAGES >= 2).
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset, clears every stage
//   d_in   in   asynchronous level
//   d_out  out  synchronised level (last stage)

module ff_synch #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/lvds_tx_bridge.sv
// rtl/lvds_tx_bridge.sv - parallel-to-serial-domain word bridge with FIFO and two-phase handshake
//
// Purpose: buffers lane-packed words in a small FIFO and hands them one at a
// time to the serial domain with a two-phase req/ack toggle handshake. While
// train_en is set, the training pattern is sent on every lane instead of
// FIFO data.
// Ports:
//   clk_sys           in   parallel-domain clock
//   reset_n           in   asynchronous active-low reset
//   tx_data_in        in   NUM_LANES*PARALLEL_WIDTH write data, lane 0 in LSBs
//   tx_data_valid     in   write request
//   tx_data_ready     out  FIFO can accept a word
//   train_en          in   send TRAIN_PATTERN instead of FIFO data
//   tx_parallel_word  out  word held for the serial domain
//   tx_word_req       out  request toggle
//   ack_serial        in   acknowledge toggle (asynchronous)
//   fifo_level        out  FIFO occupancy
//   words_sent        out  completed handshakes, wraps at 16 bits
//   busy              out  handshake outstanding

module lvds_tx_bridge
    import lvds_tx_bridge_pkg::*;
#(
    parameter int                          PARALLEL_WIDTH = 8,
    parameter int                          NUM_LANES      = 4,
    parameter int                          FIFO_DEPTH     = 4,
    parameter logic [PARALLEL_WIDTH-1:0]   TRAIN_PATTERN  = PARALLEL_WIDTH'(TRAIN_PATTERN_DEFAULT)
) (
    input  logic                                  clk_sys,
    input  logic                                  reset_n,
    input  logic [NUM_LANES*PARALLEL_WIDTH-1:0]   tx_data_in,
    input  logic                                  tx_data_valid,
    output logic                                  tx_data_ready,
    input  logic                                  train_en,
    output logic [NUM_LANES*PARALLEL_WIDTH-1:0]   tx_parallel_word,
    output logic                                  tx_word_req,
    input  logic                                  ack_serial,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
    output logic [15:0]                           words_sent,
    output logic                                  busy
);

    localparam int                WORD_W    = NUM_LANES * PARALLEL_WIDTH;
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                LVL_W     = PTR_W + 1;
    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    logic [0:0]        state_q,      state_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [LVL_W-1:0]  level_q,      level_d;
    logic [WORD_W-1:0] word_q,       word_d;
    logic              req_q,        req_d;
    logic [15:0]       words_sent_q, words_sent_d;
    logic              ready_en_q,   ready_en_d;

    logic              ack_sync;
    logic              push;
    logic              pop;

    ff_synch #(
        .STAGES (2)
    ) u_ack_synch (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .d_in  (ack_serial),
        .d_out (ack_sync)
    );

    // ready_en_q holds ready low through reset and rises on the first edge
    // after release, so a write can never race the reset deassertion.
    assign tx_data_ready = ready_en_q && (level_q < DEPTH_LVL);
    assign push          = tx_data_valid && tx_data_ready;

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        word_d       = word_q;
        req_d        = req_q;
        words_sent_d = words_sent_q;
        ready_en_d   = 1'b1;
        pop          = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = tx_data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (state_q == ST_IDLE) begin
            // Training has priority and leaves the FIFO untouched. Acks seen
            // here are ignored: the next launch re-arms the comparison.
            if (train_en) begin
                word_d  = {NUM_LANES{TRAIN_PATTERN}};
                req_d   = ~req_q;
                state_d = ST_WAIT_ACK;
            end else if (level_q != '0) begin
                word_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
                pop      = 1'b1;
                req_d    = ~req_q;
                state_d  = ST_WAIT_ACK;
            end
        end else begin
            if (ack_sync == req_q) begin
                state_d      = ST_IDLE;
                words_sent_d = words_sent_q + 16'd1;
            end
        end

        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            word_q       <= '0;
            req_q        <= 1'b0;
            words_sent_q <= 16'd0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            word_q       <= word_d;
            req_q        <= req_d;
            words_sent_q <= words_sent_d;
            ready_en_q   <= ready_en_d;
        end
    end

    assign tx_parallel_word = word_q;
    assign tx_word_req      = req_q;
    assign fifo_level       = level_q;
    assign words_sent       = words_sent_q;
    assign busy             = (state_q == ST_WAIT_ACK);

endmodule

// File: tb/tb_lvds_tx_bridge.sv
// tb/tb_lvds_tx_bridge.sv - self-checking bench for lvds_tx_bridge

module tb_lvds_tx_bridge;

    localparam int D  = 4;
    localparam int NL = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] tx_data_in = '0;
    logic        tx_data_valid = 1'b0;
    logic        tx_data_ready;
    logic        train_en = 1'b0;
    logic [31:0] tx_parallel_word;
    logic        tx_word_req;
    logic        ack_serial = 1'b0;
    logic [2:0]  fifo_level;
    logic [15:0] words_sent;
    logic        busy;

    always #5 clk_sys = ~clk_sys;

    lvds_tx_bridge dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .tx_data_in       (tx_data_in),
        .tx_data_valid    (tx_data_valid),
        .tx_data_ready    (tx_data_ready),
        .train_en         (train_en),
        .tx_parallel_word (tx_parallel_word),
        .tx_word_req      (tx_word_req),
        .ack_serial       (ack_serial),
        .fifo_level       (fifo_level),
        .words_sent       (words_sent),
        .busy             (busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, one outstanding word, ack seen
    // two clk_sys edges after it is applied.
    logic [31:0] m_q[$];
    bit          m_busy, m_req, m_init, m_s1, m_s2, m_accept;
    logic [31:0] m_word;
    logic [15:0] m_count;

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_busy = 0; m_req = 0; m_init = 0; m_s1 = 0; m_s2 = 0;
            m_word = '0; m_count = '0;
        end else begin
            m_accept = tx_data_valid && m_init && (m_q.size() < D);
            if (!m_busy) begin
                if (train_en) begin
                    m_word = {NL{8'hA5}};
                    m_req  = !m_req;
                    m_busy = 1;
                end else if (m_q.size() > 0) begin
                    m_word = m_q.pop_front();
                    m_req  = !m_req;
                    m_busy = 1;
                end
            end else if (m_s2 == m_req) begin
                m_busy  = 0;
                m_count = m_count + 16'd1;
            end
            if (m_accept) m_q.push_back(tx_data_in);
            m_s2   = m_s1;
            m_s1   = ack_serial;
            m_init = 1;
        end
    end

    always @(negedge clk_sys) begin
        check("ready", tx_data_ready, (m_init && m_q.size() < D));
        check("level", fifo_level, m_q.size());
        check("busy", busy, m_busy);
        check("req", tx_word_req, m_req);
        check("word", tx_parallel_word, m_word);
        check("words_sent", words_sent, m_count);
    end

    // Serial-domain partner: mirrors req onto ack after ack_delay cycles.
    int ack_delay = 3;
    bit ack_hold  = 0;
    int ack_cnt   = 0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            ack_serial = 1'b0;
            ack_cnt    = 0;
        end else if (!ack_hold && ack_serial != tx_word_req) begin
            if (ack_cnt >= ack_delay) begin
                ack_serial = tx_word_req;
                ack_cnt    = 0;
            end else begin
                ack_cnt++;
            end
        end
    end

    // Record every launched word.
    logic [31:0] log_q[$];
    logic        prev_req = 1'b0;

    always @(negedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_req = 1'b0;
        end else begin
            if (tx_word_req != prev_req) log_q.push_back(tx_parallel_word);
            prev_req = tx_word_req;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send(input logic [31:0] w);
        int t = 0;
        @(negedge clk_sys);
        tx_data_in    = w;
        tx_data_valid = 1'b1;
        while (!tx_data_ready && t < 200) begin
            @(negedge clk_sys);
            t++;
        end
        check("send_accepted", (t < 200), 1);
        @(negedge clk_sys);
        tx_data_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int t = 0;
        while ((busy || fifo_level != 0) && t < 1000) begin
            @(negedge clk_sys);
            t++;
        end
        check({name, "_drain"}, (t < 1000), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] fw[5];
        logic [31:0] tw[2];
        logic [31:0] cw[4];
        logic [31:0] rw;
        int          base, tcnt, t;
        logic [15:0] saved;

        // Reset values
        cyc(3);
        check("rst_ready", tx_data_ready, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_word", tx_parallel_word, 0);
        check("rst_req", tx_word_req, 0);
        check("rst_words_sent", words_sent, 0);
        reset_n = 1'b1;
        #1 check("ready_at_release", tx_data_ready, 0);
        @(negedge clk_sys);
        check("ready_first_edge", tx_data_ready, 1);

        // Single word
        ack_delay = 3;
        send(32'h1122_3344);
        check("single_level_after_write", fifo_level, 1);
        @(negedge clk_sys);
        check("single_word", tx_parallel_word, 32'h1122_3344);
        check("single_req", tx_word_req, 1);
        check("single_busy", busy, 1);
        t = 0;
        while (busy && t < 50) begin @(negedge clk_sys); t++; end
        check("single_done", (t < 50), 1);
        check("single_words_sent", words_sent, 1);

        // Fill with acks withheld
        ack_hold = 1;
        foreach (fw[i]) fw[i] = $urandom;
        base = log_q.size();
        foreach (fw[i]) send(fw[i]);
        cyc(1);
        check("fill_level", fifo_level, 4);
        check("fill_ready", tx_data_ready, 0);
        check("fill_busy", busy, 1);
        ack_hold = 0;
        wait_drained("fill");
        check("fill_count", log_q.size() - base, 5);
        for (int i = 0; i < 5; i++) check("fill_order", log_q[base + i], fw[i]);
        check("fill_words_sent", words_sent, 6);

        // Training with two buffered words
        ack_hold = 1;
        tw[0] = $urandom; tw[1] = $urandom;
        base = log_q.size();
        @(negedge clk_sys);
        train_en = 1'b1;
        send(tw[0]);
        send(tw[1]);
        cyc(1);
        check("train_level_held", fifo_level, 2);
        ack_hold = 0;
        cyc(30);
        check("train_level_stays", fifo_level, 2);
        check("train_word", tx_parallel_word, 32'hA5A5_A5A5);
        train_en = 1'b0;
        wait_drained("train");
        tcnt = log_q.size() - base - 2;
        check("train_launches", (tcnt >= 2), 1);
        for (int i = 0; i < tcnt; i++) check("train_pattern", log_q[base + i], 32'hA5A5_A5A5);
        check("train_then_w0", log_q[base + tcnt], tw[0]);
        check("train_then_w1", log_q[base + tcnt + 1], tw[1]);

        // Push and pop on the same edge at level 2
        ack_hold = 1;
        foreach (cw[i]) cw[i] = $urandom;
        base = log_q.size();
        send(cw[0]); send(cw[1]); send(cw[2]);
        cyc(1);
        check("sim_level_pre", fifo_level, 2);
        ack_hold = 0;
        t = 0;
        while (busy && t < 50) begin @(negedge clk_sys); t++; end
        check("sim_idle_seen", (t < 50), 1);
        tx_data_in    = cw[3];
        tx_data_valid = 1'b1;
        @(negedge clk_sys);
        tx_data_valid = 1'b0;
        check("sim_level_same", fifo_level, 2);
        check("sim_busy", busy, 1);
        wait_drained("sim");
        for (int i = 0; i < 4; i++) check("sim_order", log_q[base + i], cw[i]);

        // Spurious ack toggle while idle
        ack_hold = 1;
        cyc(1);
        saved = m_count;
        ack_serial = ~ack_serial;
        cyc(6);
        check("spurious_count", words_sent, saved);
        check("spurious_busy", busy, 0);
        ack_serial = ~ack_serial;
        cyc(4);
        ack_hold = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            tx_data_valid = ($urandom_range(0, 99) < 60);
            tx_data_in    = $urandom;
            if ($urandom_range(0, 99) < 3) train_en = ~train_en;
            if ($urandom_range(0, 99) < 5) ack_hold = ~ack_hold;
            if ($urandom_range(0, 99) < 5) ack_delay = $urandom_range(0, 5);
        end
        @(negedge clk_sys);
        tx_data_valid = 1'b0;
        train_en      = 1'b0;
        ack_hold      = 0;
        wait_drained("random");

        // Reset in the middle of a handshake
        ack_hold = 1;
        send(32'hDEAD_BEEF);
        t = 0;
        while (!busy && t < 20) begin @(negedge clk_sys); t++; end
        check("midrst_busy_before", busy, 1);
        @(posedge clk_sys);
        #3;
        reset_n    = 1'b0;
        ack_serial = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", tx_data_ready, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_word", tx_parallel_word, 0);
        check("midrst_req", tx_word_req, 0);
        check("midrst_words_sent", words_sent, 0);
        cyc(3);
        reset_n  = 1'b1;
        ack_hold = 0;
        rw = $urandom;
        send(rw);
        wait_drained("midrst");
        check("midrst_after_count", words_sent, 1);
        check("midrst_after_word", tx_parallel_word, rw);

        // words_sent wrap
        @(negedge clk_sys);
        force dut.words_sent_q = 16'hFFFF;
        m_count = 16'hFFFF;
        @(negedge clk_sys);
        release dut.words_sent_q;
        check("wrap_preload", words_sent, 16'hFFFF);
        send($urandom);
        wait_drained("wrap");
        check("wrap_zero", words_sent, 0);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
